// File: rtl/api_slave.sv
// Serial work-frame receiver and result-block transmitter clocked from the
// system clock; load/sck/mosi are oversampled through 2-flop synchronizers.
module api_slave #(
   parameter int WORK_LEN = 23,
   parameter int RES_LEN  = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        sck,
   input  logic        mosi,
   output logic        miso,
   output logic        work_wr_en,
   output logic [4:0]  work_addr,
   output logic [31:0] work_dat,
   output logic        work_vld,
   input  logic        res_wr_en,
   input  logic [3:0]  res_addr,
   input  logic [31:0] res_dat,
   input  logic        res_commit,
   output logic        res_rdy
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [7:0] WORK_LEN8 = 8'(WORK_LEN);
   localparam logic [7:0] RES_LEN8  = 8'(RES_LEN);

   state_t      state;
   logic [2:0]  load_p, sck_p;
   logic [1:0]  mosi_p;
   logic        load_fall, load_rise, sck_rise, sck_fall, mosi_s;
   logic [31:0] shift_reg, tx_sr, tx_next;
   logic [4:0]  bit_cnt;
   logic [7:0]  word_cnt, fetch_idx;
   logic        use_buf, fetch_en;
   logic [31:0] res_buf [16];

   // load chain resets low so a load held low through reset never looks like a fresh falling edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         load_p <= '0;
         sck_p  <= '0;
         mosi_p <= '0;
      end else begin
         load_p <= {load_p[1:0], load};
         sck_p  <= {sck_p[1:0], sck};
         mosi_p <= {mosi_p[0], mosi};
      end
   end

   assign load_fall = load_p[2] & ~load_p[1];
   assign load_rise = ~load_p[2] & load_p[1];
   assign sck_rise  = ~sck_p[2] & sck_p[1];
   assign sck_fall  = sck_p[2] & ~sck_p[1];
   assign mosi_s    = mosi_p[1];

   always_ff @(posedge clk) begin
      if (res_wr_en && !res_rdy && ({4'b0, res_addr} < RES_LEN8))
         res_buf[res_addr] <= res_dat;
   end

   // In IDLE the fetch targets word 0 of the frame about to start, using live res_rdy
   always_comb begin
      fetch_idx = (state == IDLE) ? '0 : word_cnt;
      fetch_en  = (state == IDLE) ? res_rdy : use_buf;
      tx_next   = '1;
      if (fetch_en && (fetch_idx < RES_LEN8))
         tx_next = res_buf[fetch_idx[3:0]];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         shift_reg  <= '0;
         tx_sr      <= '0;
         bit_cnt    <= '0;
         word_cnt   <= '0;
         use_buf    <= 1'b0;
         miso       <= 1'b1;
         work_wr_en <= 1'b0;
         work_addr  <= '0;
         work_dat   <= '0;
         work_vld   <= 1'b0;
         res_rdy    <= 1'b0;
      end else begin
         work_wr_en <= 1'b0;
         work_vld   <= 1'b0;
         if (res_commit && !res_rdy)
            res_rdy <= 1'b1;
         case (state)
            IDLE: begin
               miso <= 1'b1;
               if (load_fall) begin
                  state    <= SHIFT;
                  bit_cnt  <= '0;
                  word_cnt <= '0;
                  use_buf  <= res_rdy;
                  miso     <= tx_next[31];
                  tx_sr    <= {tx_next[30:0], 1'b0};
               end
            end
            SHIFT: begin
               if (load_rise) begin
                  state <= DONE;
                  miso  <= 1'b1;
               end else if (sck_rise) begin
                  shift_reg <= {shift_reg[30:0], mosi_s};
                  bit_cnt   <= bit_cnt + 5'd1;
                  if (bit_cnt == 5'd31) begin
                     if (word_cnt != 8'hFF)
                        word_cnt <= word_cnt + 8'd1;
                     if (word_cnt < WORK_LEN8) begin
                        work_wr_en <= 1'b1;
                        work_addr  <= word_cnt[4:0];
                        work_dat   <= {shift_reg[30:0], mosi_s};
                     end
                  end
               end else if (sck_fall) begin
                  // bit_cnt==0 here means a whole word just went out: start the next one
                  if (bit_cnt == 5'd0) begin
                     miso  <= tx_next[31];
                     tx_sr <= {tx_next[30:0], 1'b0};
                  end else begin
                     miso  <= tx_sr[31];
                     tx_sr <= {tx_sr[30:0], 1'b0};
                  end
               end
            end
            DONE: begin
               miso     <= 1'b1;
               state    <= IDLE;
               work_vld <= (word_cnt >= WORK_LEN8) && (bit_cnt == 5'd0);
               if (word_cnt >= RES_LEN8)
                  res_rdy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_api_slave.sv
// Scoreboard bench for api_slave: stimulus queues expected work writes, pulses and
// miso words; independent monitors pop and compare as the DUT produces them.
module tb_api_slave;
   localparam int WORK_LEN = 23;
   localparam int RES_LEN  = 11;

   logic        clk = 1'b0;
   logic        rst, load, sck, mosi, miso;
   logic        work_wr_en, work_vld;
   logic [4:0]  work_addr;
   logic [31:0] work_dat;
   logic        res_wr_en, res_commit, res_rdy;
   logic [3:0]  res_addr;
   logic [31:0] res_dat;

   always #5 clk = ~clk;

   api_slave #(.WORK_LEN(WORK_LEN), .RES_LEN(RES_LEN)) dut (
      .clk(clk), .rst(rst), .load(load), .sck(sck), .mosi(mosi), .miso(miso),
      .work_wr_en(work_wr_en), .work_addr(work_addr), .work_dat(work_dat),
      .work_vld(work_vld), .res_wr_en(res_wr_en), .res_addr(res_addr),
      .res_dat(res_dat), .res_commit(res_commit), .res_rdy(res_rdy)
   );

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] dat;
   } wr_t;

   int          total = 0;
   int          bad   = 0;
   wr_t         work_q[$];
   logic [31:0] tx_q[$];
   int          vld_q[$];
   logic [31:0] mdl_buf [RES_LEN];
   bit          mdl_rdy = 1'b0;
   int          mbits = 0;
   logic [31:0] mword = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // work write / frame-valid monitor
   always @(negedge clk) begin
      wr_t e;
      if (work_wr_en === 1'b1) begin
         chk("work_expected", 32'(work_q.size() > 0), 32'd1);
         if (work_q.size() > 0) begin
            e = work_q.pop_front();
            chk("work_addr", {27'b0, work_addr}, {27'b0, e.addr});
            chk("work_dat", work_dat, e.dat);
         end
      end
      if (work_vld === 1'b1) begin
         chk("vld_expected", 32'(vld_q.size() > 0), 32'd1);
         if (vld_q.size() > 0) void'(vld_q.pop_front());
      end
   end

   // miso monitor: master-side view, sampled on sck rising; partial words dropped at load rise
   always @(posedge sck or posedge load) begin
      logic [31:0] exp;
      if (load === 1'b1) begin
         mbits = 0;
      end else begin
         mword = {mword[30:0], miso};
         mbits++;
         if (mbits == 32) begin
            mbits = 0;
            chk("miso_expected", 32'(tx_q.size() > 0), 32'd1);
            if (tx_q.size() > 0) begin
               exp = tx_q.pop_front();
               chk("miso_word", mword, exp);
            end
         end
      end
   end

   task automatic res_write(input logic [3:0] a, input logic [31:0] d);
      @(negedge clk);
      res_wr_en = 1'b1; res_addr = a; res_dat = d;
      @(negedge clk);
      res_wr_en = 1'b0;
      if (!mdl_rdy && int'(a) < RES_LEN) mdl_buf[int'(a)] = d;
   endtask

   task automatic commit();
      @(negedge clk); res_commit = 1'b1;
      @(negedge clk); res_commit = 1'b0;
      mdl_rdy = 1'b1;
      chk("res_rdy_commit", {31'b0, res_rdy}, {31'b0, mdl_rdy});
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_miso"}, {31'b0, miso}, 32'd1);
      chk({tag, "_wr_en"}, {31'b0, work_wr_en}, 32'd0);
      chk({tag, "_vld"}, {31'b0, work_vld}, 32'd0);
   endtask

   // nwords full words plus xbits extra bits; seq uses data n, rst_mid resets at the end instead of load rise
   task automatic spi_frame(input int nwords, input int xbits, input int hp, input bit seq, input bit rst_mid);
      logic [31:0] data[$];
      logic [31:0] w;
      wr_t         e;
      for (int n = 0; n <= nwords; n++) begin
         w = seq ? 32'(n) : $urandom;
         data.push_back(w);
         if (n < nwords) begin
            if (n < WORK_LEN) begin
               e.addr = 5'(n); e.dat = w;
               work_q.push_back(e);
            end
            tx_q.push_back((mdl_rdy && n < RES_LEN) ? mdl_buf[n] : 32'hFFFF_FFFF);
         end
      end
      if (!rst_mid && nwords >= WORK_LEN && xbits == 0) vld_q.push_back(1);

      @(negedge clk);
      load = 1'b0;
      for (int b = 0; b < nwords * 32 + xbits; b++) begin
         w = data[b / 32];
         mosi = w[31 - (b % 32)];
         repeat (hp) @(negedge clk);
         sck = 1'b1;
         repeat (hp) @(negedge clk);
         sck = 1'b0;
      end
      if (rst_mid) begin
         repeat (2) @(negedge clk);
         rst = 1'b1;
         repeat (3) @(negedge clk);
         chk_idle("rst_mid");
         chk("rst_mid_rdy", {31'b0, res_rdy}, 32'd0);
         rst = 1'b0;
         mdl_rdy = 1'b0;
      end
      repeat (hp) @(negedge clk);
      load = 1'b1;
      repeat (12) @(negedge clk);
      if (!rst_mid && nwords >= RES_LEN) mdl_rdy = 1'b0;
      chk("work_drained", 32'(work_q.size()), 32'd0);
      chk("vld_drained", 32'(vld_q.size()), 32'd0);
      chk("miso_drained", 32'(tx_q.size()), 32'd0);
      chk("res_rdy_after", {31'b0, res_rdy}, {31'b0, mdl_rdy});
      chk("miso_idle", {31'b0, miso}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; load = 1'b1; sck = 1'b0; mosi = 1'b0;
      res_wr_en = 1'b0; res_commit = 1'b0; res_addr = '0; res_dat = '0;
      repeat (4) @(negedge clk);
      chk_idle("reset");
      chk("reset_rdy", {31'b0, res_rdy}, 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk_idle("post_reset");

      // sequential work words, no result buffer armed
      spi_frame(WORK_LEN, 0, 8, 1'b1, 1'b0);

      for (int n = 0; n < RES_LEN; n++) res_write(4'(n), 32'hA000_0000 + 32'(n));
      commit();
      spi_frame(WORK_LEN, 0, 8, 1'b0, 1'b0);

      // short aborted frame keeps buffer armed
      for (int n = 0; n < RES_LEN; n++) res_write(4'(n), 32'hB000_0000 + 32'(n));
      commit();
      spi_frame(5, 7, 8, 1'b0, 1'b0);

      // write while armed is ignored
      res_write(4'd0, 32'h1234_5678);
      commit();
      spi_frame(WORK_LEN, 0, 8, 1'b0, 1'b0);

      spi_frame(40, 0, 4, 1'b0, 1'b0);

      for (int n = 0; n < RES_LEN; n++) res_write(4'(n), 32'hC000_0000 + 32'(n));
      commit();
      spi_frame(3, 10, 6, 1'b0, 1'b1);
      spi_frame(WORK_LEN, 0, 8, 1'b1, 1'b0);

      for (int i = 0; i < 3; i++) begin
         for (int n = 0; n < RES_LEN; n++) res_write(4'(n), $urandom);
         for (int k = 0; k < 3; k++) res_write(4'($urandom_range(0, 15)), $urandom);
         if ($urandom_range(0, 2) != 0) commit();
         spi_frame($urandom_range(0, 26),
                   ($urandom_range(0, 3) == 0) ? $urandom_range(1, 31) : 0,
                   $urandom_range(4, 6), 1'b0, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/api_slave.md
API_SLAVE -- requirements
Module: api_slave

Interface
REQ-001 Parameter WORK_LEN, default 23: words per work frame captured.
REQ-002 Parameter RES_LEN, default 11: words per result block returned.
REQ-003 clk  input  1  single clock; all logic synchronous to it.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 load  input  1  chip select, active-low; asynchronous to clk.
REQ-006 sck  input  1  serial clock, idle low; asynchronous to clk.
REQ-007 mosi  input  1  serial data from master.
REQ-008 miso  output  1  serial data to master; 1 when deselected.
REQ-009 work_wr_en  output  1  one-cycle strobe per captured work word.
REQ-010 work_addr  output  5  word index 0..WORK_LEN-1 of work_dat.
REQ-011 work_dat  output  32  captured word.
REQ-012 work_vld  output  1  one-cycle pulse: complete work frame received.
REQ-013 res_wr_en  input  1  result buffer write strobe.
REQ-014 res_addr  input  4  result word index 0..RES_LEN-1.
REQ-015 res_dat  input  32  result word.
REQ-016 res_commit  input  1  one-cycle pulse marking result buffer ready.
REQ-017 res_rdy  output  1  result buffer armed for transmission.

Function
REQ-018 load, sck, mosi SHALL each pass a 2-flop synchronizer; edges detected on synchronized values; sck half-period SHALL be at least 4 clk.
REQ-019 States: IDLE, SHIFT, DONE; IDLE->SHIFT on synchronized load falling; SHIFT->DONE on load rising; DONE->IDLE next cycle.
REQ-020 In SHIFT, mosi SHALL be sampled on each synchronized sck rising edge into a 32-bit shift register, MSB first.
REQ-021 Bit counter 0..31 wraps; on 32nd bit, word counter (8-bit, saturating at 255) SHALL increment.
REQ-022 On word completion with word index < WORK_LEN: work_wr_en high one cycle, work_addr = index, work_dat = received word, within 2 clk of the 32nd sck rising edge.
REQ-023 Words with index >= WORK_LEN SHALL be discarded (no strobe).
REQ-024 In DONE, work_vld SHALL pulse one cycle iff word counter >= WORK_LEN and bit counter = 0; otherwise frame is aborted, no pulse.
REQ-025 miso SHALL present MSB of tx word 0 within 3 clk of synchronized load falling, and shift next bit within 3 clk of each synchronized sck falling edge; after 32 bits next tx word's MSB is presented.
REQ-026 tx word n = result buffer word n when res_rdy=1 and n < RES_LEN; otherwise 32'hFFFFFFFF.
REQ-027 miso SHALL be 1 in IDLE and DONE.
REQ-028 res_wr_en SHALL write res_dat to res_addr only when res_rdy=0; writes with res_rdy=1 or res_addr >= RES_LEN ignored.
REQ-029 res_commit SHALL set res_rdy next cycle; res_commit with res_rdy=1 has no effect.
REQ-030 res_rdy SHALL clear in DONE iff at least RES_LEN complete words were shifted in that frame; a shorter frame leaves res_rdy set and buffer intact.
REQ-031 res_commit arriving during SHIFT SHALL set res_rdy but the tx source for the current frame SHALL remain latched at load falling.
REQ-032 sck edges while in IDLE or DONE SHALL be ignored.

Reset
REQ-033 On rst: state IDLE, counters 0, miso=1, work_wr_en=0, work_vld=0, res_rdy=0, result buffer contents don't-care.
REQ-034 rst asserted mid-frame SHALL abort immediately; after release, a new frame begins only on a fresh load falling edge.

Verification
REQ-035 Send 23 words 0x00000000..0x00000016 at sck half-period 8 clk -> 23 work_wr_en strobes, addr 0..22 matching data, one work_vld.
REQ-036 Write result words 0xA0000000+n (n=0..10), res_commit, run 23-word frame -> miso returns 0xA0000000..0xA000000A then 12 words 0xFFFFFFFF; res_rdy=0 after frame.
REQ-037 Deassert load after 5 words + 7 bits -> 5 strobes, no work_vld, res_rdy unchanged.
REQ-038 Frame of 40 words -> exactly 23 strobes, work_vld pulses once.
REQ-039 res_wr_en of 0x12345678 to addr 0 while res_rdy=1 -> ignored; next frame returns original word 0.
REQ-040 Assert rst during word 3 -> outputs at reset values; subsequent full frame captured correctly from addr 0.
